hazard_scoreboard: RTL and testbench

- Parametrised successor to the combinational FD/DX/XM data-hazard check.
- Tracks every in-flight register write with a per-register countdown, so it covers mixed-latency producers: 1-cycle ALU, LOAD_LAT load, MD_LAT multdiv.
- Sits at the decode→execute boundary and produces the stall, per-source forward hits and multdiv structural stall for the pipeline.
- Replaces the fixed two-stage lookback with a depth-independent scoreboard.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_reg_counter.sv | 31 +++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the issue-stage hazard scoreboard: instruction classes,
// the hardwired zero register and the class-to-latency mapping.
package hazard_pkg;

    localparam logic [1:0] CLS_ALU     = 2'd0;
    localparam logic [1:0] CLS_LOAD    = 2'd1;
    localparam logic [1:0] CLS_MD      = 2'd2;
    localparam logic [1:0] CLS_NOWRITE = 2'd3;

    localparam int REG_ZERO = 0;

    // Cycles from issue until the result reaches the register file.
    function automatic int lat(input logic [1:0] cls, input int load_lat, input int md_lat);
        case (cls)
            CLS_ALU:  return 1;
            CLS_LOAD: return load_lat;
            CLS_MD:   return md_lat;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Loadable down counter that stops at zero; one per tracked register plus one
// for the multdiv unit. Load wins over the decrement in the same cycle.
module hazard_reg_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             is_zero,
    output logic             is_one
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (r_value != '0) begin
            r_value <= r_value - CNT_W'(1);
        end
    end

    assign value   = r_value;
    assign is_zero = (r_value == '0);
    assign is_one  = (r_value == CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode->execute hazard scoreboard: per-register write countdowns give RAW/WAW/multdiv
// stalls with zero-cycle combinational latency. HAZARD_FWD_EN enables the cnt==1 bypass.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_READ = 2,
    parameter int LOAD_LAT = 2,
    parameter int MD_LAT   = 17,
    parameter int CNT_W    = $clog2(MD_LAT + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iss_valid,
    input  logic                       iss_we,
    input  logic [REG_AW-1:0]          iss_rd,
    input  logic [1:0]                 iss_class,
    input  logic [NUM_READ*REG_AW-1:0] iss_rs,
    input  logic [NUM_READ-1:0]        iss_re,
    input  logic                       flush,
    output logic                       stall,
    output logic                       iss_accept,
    output logic [NUM_READ-1:0]        src_fwd,
    output logic                       md_busy,
    output logic [2**REG_AW-1:0]       pending
);

    localparam int NUM_REGS = 2**REG_AW;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_is_zero;
    logic [NUM_REGS-1:0] w_is_one;
    logic [CNT_W-1:0]    w_lat;
    logic                w_reg_load;
    logic                w_md_load;
    logic                w_md_zero;
    logic                w_md_one;
    logic [CNT_W-1:0]    w_unused_md_cnt;
    logic [REG_AW-1:0]   w_rs [NUM_READ];
    logic [NUM_READ-1:0] w_raw;
    logic                w_waw;
    logic                w_struct;

    assign w_lat = CNT_W'(lat(iss_class, LOAD_LAT, MD_LAT));

    // Register zero is hardwired, so its slot is a constant "already written".
    assign w_cnt[0]     = '0;
    assign w_is_zero[0] = 1'b1;
    assign w_is_one[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        hazard_reg_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .load     (w_reg_load && (iss_rd == REG_AW'(r))),
            .load_val (w_lat),
            .value    (w_cnt[r]),
            .is_zero  (w_is_zero[r]),
            .is_one   (w_is_one[r])
        );
    end

    hazard_reg_counter #(.CNT_W(CNT_W)) u_md_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_md_load),
        .load_val (CNT_W'(MD_LAT)),
        .value    (w_unused_md_cnt),
        .is_zero  (w_md_zero),
        .is_one   (w_md_one)
    );

    // Busy only while the result is not yet on the bypass, so a follow-on
    // multdiv can issue in the cycle its predecessor forwards.
    assign md_busy = ~w_md_zero & ~w_md_one;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_src
        assign w_rs[i]    = iss_rs[i*REG_AW +: REG_AW];
        assign w_raw[i]   = iss_re[i] && (w_rs[i] != REG_AW'(REG_ZERO)) &&
                            !w_is_zero[w_rs[i]] && !(FWD_ON && w_is_one[w_rs[i]]);
        assign src_fwd[i] = FWD_ON && iss_valid && iss_re[i] &&
                            (w_rs[i] != REG_AW'(REG_ZERO)) && w_is_one[w_rs[i]];
    end

    // In-order completion: a younger write may not land before an older one.
    assign w_waw = iss_we && (iss_rd != REG_AW'(REG_ZERO)) && (iss_class != CLS_NOWRITE) &&
                   (w_cnt[iss_rd] > w_lat);

    assign w_struct   = (iss_class == CLS_MD) && md_busy;
    assign stall      = iss_valid && !flush && ((|w_raw) || w_waw || w_struct);
    assign iss_accept = iss_valid && !stall && !flush;

    assign w_reg_load = iss_accept && iss_we && (iss_class != CLS_NOWRITE) &&
                        (iss_rd != REG_AW'(REG_ZERO));
    assign w_md_load  = iss_accept && (iss_class == CLS_MD);

    assign pending = ~w_is_zero;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized issue traffic
// compared against a countdown-array model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int NUM_READ = 2;
    localparam int LOAD_LAT = 2;
    localparam int MD_LAT   = 17;
    localparam int NREGS    = 32;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic        iss_we;
    logic [4:0]  iss_rd;
    logic [1:0]  iss_class;
    logic [9:0]  iss_rs;
    logic [1:0]  iss_re;
    logic        flush;
    logic        stall;
    logic        iss_accept;
    logic [1:0]  src_fwd;
    logic        md_busy;
    logic [31:0] pending;

    always #5 clock = ~clock;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .NUM_READ(NUM_READ), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT)
    ) dut (
        .clock(clock), .reset(reset), .iss_valid(iss_valid), .iss_we(iss_we),
        .iss_rd(iss_rd), .iss_class(iss_class), .iss_rs(iss_rs), .iss_re(iss_re),
        .flush(flush), .stall(stall), .iss_accept(iss_accept), .src_fwd(src_fwd),
        .md_busy(md_busy), .pending(pending)
    );

    int m_cnt [NREGS];
    int m_md;
    int n_checks = 0;
    int n_fail   = 0;

    logic        e_stall, e_acc, e_busy;
    logic [1:0]  e_fwd;
    logic [31:0] e_pend;

    function automatic int lat_of(input int c);
        if (c == 0) return 1;
        if (c == 1) return LOAD_LAT;
        if (c == 2) return MD_LAT;
        return 0;
    endfunction

    // Expected outputs from the current inputs and model state.
    task automatic model_eval();
        logic haz;
        haz = 1'b0;
        e_fwd = 2'b00;
        for (int i = 0; i < NUM_READ; i++) begin
            int rs;
            int c;
            rs = int'(iss_rs[i*REG_AW +: REG_AW]);
            c  = m_cnt[rs];
            if (iss_re[i] && rs != 0 && c != 0 && !(FWD && c == 1)) haz = 1'b1;
            if (FWD && iss_valid && iss_re[i] && rs != 0 && c == 1) e_fwd[i] = 1'b1;
        end
        if (iss_we && iss_rd != 0 && iss_class != 2'd3 && m_cnt[iss_rd] > lat_of(int'(iss_class)))
            haz = 1'b1;
        e_busy = (m_md > 1);
        if (iss_class == 2'd2 && e_busy) haz = 1'b1;
        e_stall = iss_valid && !flush && haz;
        e_acc   = iss_valid && !flush && !haz;
        e_pend  = '0;
        for (int r = 1; r < NREGS; r++) e_pend[r] = (m_cnt[r] != 0);
    endtask

    task automatic tick();
        logic acc;
        model_eval();
        acc = e_acc;
        @(posedge clock);
        if (reset) begin
            for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
            m_md = 0;
        end else begin
            for (int r = 0; r < NREGS; r++) if (m_cnt[r] > 0) m_cnt[r]--;
            if (m_md > 0) m_md--;
            if (acc && iss_we && iss_class != 2'd3 && iss_rd != 0) m_cnt[iss_rd] = lat_of(int'(iss_class));
            if (acc && iss_class == 2'd2) m_md = MD_LAT;
        end
        #2;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] cls,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] re);
        iss_valid = v;
        iss_we    = we;
        iss_rd    = rd;
        iss_class = cls;
        iss_rs    = {rs1, rs0};
        iss_re    = re;
        flush     = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 5'd0, 2'd3, 5'd0, 5'd0, 2'b00);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (iss_accept !== 1'b0) begin n_fail++; $display("FAIL reset_accept: got %b want 0", iss_accept); end
        n_checks++; if (src_fwd !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b want 00", src_fwd); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    endtask

    task automatic test_alu_fwd();
        int st;
        drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd0, 5'd0, 2'b00);
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL alu_producer_accept: got %b want 1", iss_accept); end
        tick();
        drive(1'b1, 1'b1, 5'd10, 2'd0, 5'd3, 5'd0, 2'b01);
        st = 0;
        while (stall === 1'b1 && st < 5) begin st++; tick(); end
        n_checks++; if (st != (FWD ? 0 : 1)) begin n_fail++; $display("FAIL alu_use_stalls: got %0d want %0d", st, FWD ? 0 : 1); end
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL alu_use_accept: got %b want 1", iss_accept); end
        n_checks++; if (src_fwd !== (FWD ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL alu_use_fwd: got %b want %b", src_fwd, FWD ? 2'b01 : 2'b00); end
        tick();
        idle(3);
    endtask

    task automatic test_load_use();
        int st;
        drive(1'b1, 1'b1, 5'd5, 2'd1, 5'd0, 5'd0, 2'b00);
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL load_accept: got %b want 1", iss_accept); end
        tick();
        n_checks++; if (pending[5] !== 1'b1) begin n_fail++; $display("FAIL load_pending_set: got %b want 1", pending[5]); end
        drive(1'b1, 1'b1, 5'd11, 2'd0, 5'd5, 5'd0, 2'b01);
        st = 0;
        while (stall === 1'b1 && st < 6) begin st++; tick(); end
        n_checks++; if (st != (FWD ? 1 : 2)) begin n_fail++; $display("FAIL load_use_stalls: got %0d want %0d", st, FWD ? 1 : 2); end
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL load_use_accept: got %b want 1", iss_accept); end
        n_checks++; if (src_fwd !== (FWD ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL load_use_fwd: got %b want %b", src_fwd, FWD ? 2'b01 : 2'b00); end
        tick();
        n_checks++; if (pending[5] !== 1'b0) begin n_fail++; $display("FAIL load_pending_clear: got %b want 0", pending[5]); end
        idle(5);
    endtask

    task automatic test_md_back_to_back();
        int st;
        int busy_bad;
        drive(1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 5'd0, 2'b00);
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL md1_accept: got %b want 1", iss_accept); end
        tick();
        drive(1'b1, 1'b1, 5'd8, 2'd2, 5'd0, 5'd0, 2'b00);
        st = 0;
        busy_bad = 0;
        while (stall === 1'b1 && st < 40) begin
            if (md_busy !== 1'b1) busy_bad++;
            st++;
            tick();
        end
        n_checks++; if (st != MD_LAT - 1) begin n_fail++; $display("FAIL md_struct_stalls: got %0d want %0d", st, MD_LAT - 1); end
        n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL md_busy_during_stall: got %0d idle cycles want 0", busy_bad); end
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL md2_accept: got %b want 1", iss_accept); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_busy_at_bypass: got %b want 0", md_busy); end
        tick();
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_after_md2: got %b want 1", md_busy); end
        idle(20);
    endtask

    task automatic test_waw();
        int st;
        drive(1'b1, 1'b1, 5'd4, 2'd2, 5'd0, 5'd0, 2'b00);
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL waw_md_accept: got %b want 1", iss_accept); end
        tick();
        drive(1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL waw_r0_accept: got %b want 1", iss_accept); end
        tick();
        n_checks++; if (pending !== 32'h0000_0010) begin n_fail++; $display("FAIL waw_r0_pending: got %h want 00000010", pending); end
        drive(1'b1, 1'b1, 5'd4, 2'd0, 5'd0, 5'd0, 2'b00);
        st = 0;
        while (stall === 1'b1 && st < 40) begin st++; tick(); end
        n_checks++; if (st != MD_LAT - 2) begin n_fail++; $display("FAIL waw_stalls: got %0d want %0d", st, MD_LAT - 2); end
        n_checks++; if (iss_accept !== 1'b1) begin n_fail++; $display("FAIL waw_alu_accept: got %b want 1", iss_accept); end
        tick();
        n_checks++; if (pending[4] !== 1'b1) begin n_fail++; $display("FAIL waw_alu_pending: got %b want 1", pending[4]); end
        idle(20);
    endtask

    task automatic test_r0_re();
        drive(1'b1, 1'b1, 5'd6, 2'd2, 5'd0, 5'd0, 2'b00);
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd3, 5'd0, 5'd6, 2'b01);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_src_stall: got %b want 0", stall); end
        n_checks++; if (src_fwd !== 2'b00) begin n_fail++; $display("FAIL r0_src_fwd: got %b want 00", src_fwd); end
        drive(1'b1, 1'b0, 5'd0, 2'd3, 5'd6, 5'd0, 2'b00);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL re0_stall: got %b want 0", stall); end
        n_checks++; if (src_fwd !== 2'b00) begin n_fail++; $display("FAIL re0_fwd: got %b want 00", src_fwd); end
        drive(1'b1, 1'b0, 5'd0, 2'd3, 5'd6, 5'd0, 2'b01);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL re1_pending_stall: got %b want 1", stall); end
        idle(20);
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 5'd9, 2'd1, 5'd0, 5'd0, 2'b00);
        tick();
        drive(1'b1, 1'b1, 5'd13, 2'd0, 5'd9, 5'd0, 2'b01);
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
        n_checks++; if (iss_accept !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %b want 0", iss_accept); end
        tick();
        n_checks++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL flush_pending_mid: got %b want 1", pending[9]); end
        n_checks++; if (iss_accept !== 1'b0) begin n_fail++; $display("FAIL flush_accept2: got %b want 0", iss_accept); end
        tick();
        n_checks++; if (pending[9] !== 1'b0) begin n_fail++; $display("FAIL flush_pending_drain: got %b want 0", pending[9]); end
        n_checks++; if (pending[13] !== 1'b0) begin n_fail++; $display("FAIL flush_no_update: got %b want 0", pending[13]); end
        flush = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd12, 2'd2, 5'd0, 5'd0, 2'b00);
        tick();
        idle(3);
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL mid_md_busy: got %b want 1", md_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pending: got %h want 0", pending); end
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_md_busy: got %b want 0", md_busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [1:0] cls;
            cls = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 9) != 0,
                  (cls == 2'd3) ? 1'b0 : ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 7)), cls,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 199) == 0);
            #1;
            model_eval();
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %b want %b", n, stall, e_stall); end
            n_checks++; if (iss_accept !== e_acc) begin n_fail++; $display("FAIL rnd_accept cyc %0d: got %b want %b", n, iss_accept, e_acc); end
            n_checks++; if (src_fwd !== e_fwd) begin n_fail++; $display("FAIL rnd_fwd cyc %0d: got %b want %b", n, src_fwd, e_fwd); end
            n_checks++; if (md_busy !== e_busy) begin n_fail++; $display("FAIL rnd_md_busy cyc %0d: got %b want %b", n, md_busy, e_busy); end
            n_checks++; if (pending !== e_pend) begin n_fail++; $display("FAIL rnd_pending cyc %0d: got %h want %h", n, pending, e_pend); end
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
        m_md = 0;
        reset = 1'b0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_md_back_to_back();
        test_waw();
        test_r0_re();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
